control_subcmd_readarea: RTL and testbench

CONTROL_SUBCMD_READAREA -- requirements
Module: control_subcmd_readarea

---
 rtl/control_subcmd_readarea.sv | 151 +++++++++++++++
 tb/tb_control_subcmd_readarea.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/control_subcmd_readarea.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_subcmd_readarea: scans a clipped framebuffer rectangle, streams    |
// | each RAM byte out over a valid/ready channel.            Revision: 1.0     |
// +----------------------------------------------------------------------------+
module control_subcmd_readarea #(
  parameter int BYTES_PER_PIXEL = 2,
  parameter int PIXEL_HEIGHT    = 8,
  parameter int PIXEL_WIDTH     = 12,
  localparam int CB = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1,
  localparam int RB = (PIXEL_HEIGHT > 1) ? $clog2(PIXEL_HEIGHT) : 1,
  localparam int PB = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          ack,
  input  logic [CB-1:0] x1,
  input  logic [RB-1:0] y1,
  input  logic [CB:0]   width,
  input  logic [RB:0]   height,
  output logic [RB-1:0] row,
  output logic [CB-1:0] column,
  output logic [PB-1:0] pixel,
  output logic          ram_read_enable,
  input  logic [7:0]    ram_data_in,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [PB-1:0] PIX_MAX = PB'(BYTES_PER_PIXEL - 1);

  state_t        state;
  logic [CB-1:0] x_lo, x_hi;
  logic [RB-1:0] y_lo, y_hi;

  logic [CB+1:0] x_sum;
  logic [RB+1:0] y_sum;
  logic [CB-1:0] x_hi_next;
  logic [RB-1:0] y_hi_next;
  logic          empty;
  logic          last;

  // Rectangle end is clipped to the panel; the sums are one bit wider than the
  // size ports so origin+size cannot wrap before the clip compare.
  always_comb begin
    x_sum     = {2'b00, x1} + {1'b0, width} - (CB+2)'(1);
    y_sum     = {2'b00, y1} + {1'b0, height} - (RB+2)'(1);
    x_hi_next = (x_sum > (CB+2)'(PIXEL_WIDTH - 1)) ? CB'(PIXEL_WIDTH - 1) : x_sum[CB-1:0];
    y_hi_next = (y_sum > (RB+2)'(PIXEL_HEIGHT - 1)) ? RB'(PIXEL_HEIGHT - 1) : y_sum[RB-1:0];
    empty     = (width == '0) || (height == '0) ||
                ({1'b0, x1} >= (CB+1)'(PIXEL_WIDTH)) ||
                ({1'b0, y1} >= (RB+1)'(PIXEL_HEIGHT));
    last      = (row == y_lo) && (column == x_lo) && (pixel == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      row             <= '0;
      column          <= '0;
      pixel           <= '0;
      ram_read_enable <= 1'b0;
      tx_data         <= '0;
      tx_valid        <= 1'b0;
      done            <= 1'b0;
      x_lo            <= '0;
      x_hi            <= '0;
      y_lo            <= '0;
      y_hi            <= '0;
    end else if (state != IDLE && !enable) begin
      state           <= IDLE;
      ram_read_enable <= 1'b0;
      tx_valid        <= 1'b0;
      done            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            x_lo <= x1;
            y_lo <= y1;
            x_hi <= x_hi_next;
            y_hi <= y_hi_next;
            if (empty) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              row             <= y_hi_next;
              column          <= x_hi_next;
              pixel           <= PIX_MAX;
              ram_read_enable <= 1'b1;
              state           <= READ;
            end
          end
        end
        READ: begin
          ram_read_enable <= 1'b0;
          state           <= CAPTURE;
        end
        CAPTURE: begin
          tx_data  <= ram_data_in;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // pixel, then column, then row counts down, each wrapping to its high end
              if (pixel != '0) begin
                pixel <= pixel - PB'(1);
              end else begin
                pixel <= PIX_MAX;
                if (column != x_lo) begin
                  column <= column - CB'(1);
                end else begin
                  column <= x_hi;
                  row    <= row - RB'(1);
                end
              end
              ram_read_enable <= 1'b1;
              state           <= READ;
            end
          end
        end
        DONE: begin
          if (ack) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_subcmd_readarea.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_control_subcmd_readarea: directed bench for control_subcmd_readarea.    |
// |                                                          Revision: 1.0     |
// +----------------------------------------------------------------------------+
module tb_control_subcmd_readarea;
  localparam int BPP = 2;
  localparam int PH  = 8;
  localparam int PW  = 12;
  localparam int CB  = 4;
  localparam int RB  = 3;
  localparam int PB  = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          ack;
  logic [CB-1:0] x1;
  logic [RB-1:0] y1;
  logic [CB:0]   width;
  logic [RB:0]   height;
  logic [RB-1:0] row;
  logic [CB-1:0] column;
  logic [PB-1:0] pixel;
  logic          ram_read_enable;
  logic [7:0]    ram_data_in;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          done;

  int total = 0;
  int bad   = 0;

  control_subcmd_readarea #(
    .BYTES_PER_PIXEL(BPP),
    .PIXEL_HEIGHT   (PH),
    .PIXEL_WIDTH    (PW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .ack            (ack),
    .x1             (x1),
    .y1             (y1),
    .width          (width),
    .height         (height),
    .row            (row),
    .column         (column),
    .pixel          (pixel),
    .ram_read_enable(ram_read_enable),
    .ram_data_in    (ram_data_in),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .done           (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_byte(input int a);
    return 8'((a * 73 + 29) & 255);
  endfunction

  // RAM returns the addressed byte exactly one cycle after the read strobe
  always @(posedge clk)
    ram_data_in <= ram_read_enable ? ram_byte(int'({row, column, pixel})) : 8'h00;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // mode 0: tx_ready held high; mode 1: tx_ready toggles every 2 cycles
  task automatic run(input int ax, input int ay, input int aw, input int ah,
                     input int mode, input int abort_after, input string nm);
    int   exp_q[$];
    int   xe, ye, nrd, nhs, cyc, a, nseen, any_valid, extra_rd;
    bit   seen[256];
    bit   stalled;
    logic [7:0] held;
    nrd = 0; nhs = 0; cyc = 0; nseen = 0; any_valid = 0; stalled = 0; held = 0;
    foreach (seen[i]) seen[i] = 0;
    if (!(aw == 0 || ah == 0 || ax >= PW || ay >= PH)) begin
      xe = (ax + aw - 1 > PW - 1) ? PW - 1 : ax + aw - 1;
      ye = (ay + ah - 1 > PH - 1) ? PH - 1 : ay + ah - 1;
      for (int r = ye; r >= ay; r--)
        for (int c = xe; c >= ax; c--)
          for (int p = BPP - 1; p >= 0; p--)
            exp_q.push_back((r << (CB + PB)) | (c << PB) | p);
    end
    @(negedge clk);
    x1 = CB'(ax); y1 = RB'(ay); width = (CB+1)'(aw); height = (RB+1)'(ah);
    ack = 0; enable = 1; tx_ready = (mode == 0);
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (mode == 1) tx_ready = ((cyc / 2) % 2) == 1;
      if (stalled && tx_valid) chk({nm, "_stall_hold"}, tx_data, held);
      if (tx_valid) any_valid = 1;
      if (ram_read_enable) begin
        a = int'({row, column, pixel});
        chk({nm, "_addr"}, a, (nrd < exp_q.size()) ? exp_q[nrd] : -1);
        if (seen[a]) chk({nm, "_dup_read"}, a, -1);
        else nseen++;
        seen[a] = 1;
        nrd++;
      end
      if (tx_valid && tx_ready) begin
        chk({nm, "_data"}, tx_data, (nhs < exp_q.size()) ? int'(ram_byte(exp_q[nhs])) : -1);
        nhs++;
        if (nhs == abort_after) break;
      end
      stalled = tx_valid && !tx_ready;
      held    = tx_data;
      if (done) break;
    end
    chk({nm, "_no_timeout"}, int'(cyc < 3000), 1);
    if (abort_after > 0) begin
      @(negedge clk);
      chk({nm, "_abort_in_read"}, ram_read_enable, 1);
      enable = 0;
      @(negedge clk);
      chk({nm, "_abort_state"}, int'(dut.state), 0);
      chk({nm, "_abort_valid"}, tx_valid, 0);
      chk({nm, "_abort_done"}, done, 0);
      extra_rd = 0;
      repeat (6) begin
        @(negedge clk);
        if (ram_read_enable || tx_valid) extra_rd++;
      end
      chk({nm, "_abort_quiet"}, extra_rd, 0);
    end else begin
      chk({nm, "_reads"}, nrd, exp_q.size());
      chk({nm, "_bytes"}, nhs, exp_q.size());
      chk({nm, "_unique"}, nseen, exp_q.size());
      chk({nm, "_done"}, done, 1);
      if (exp_q.size() == 0) chk({nm, "_valid_seen"}, any_valid, 0);
      ack = 1; enable = 0;
      @(negedge clk);
      chk({nm, "_ack_state"}, int'(dut.state), 0);
      chk({nm, "_ack_done"}, done, 0);
      ack = 0;
    end
  endtask

  initial begin
    int cyc;
    reset = 0; enable = 0; ack = 0; tx_ready = 0;
    x1 = 0; y1 = 0; width = 0; height = 0;
    #1;
    chk("rst_addr", int'({row, column, pixel}), 0);
    chk("rst_rd", ram_read_enable, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    reset = 1;

    run(3, 5, 4, 2, 0, 0, "region");
    run(3, 5, 4, 2, 1, 0, "backpressure");
    run(PW - 2, 0, 5, 1, 0, 0, "clip");
    run(2, 2, 0, 3, 0, 0, "empty_w");
    run(PW, 1, 2, 2, 0, 0, "empty_x");
    run(3, 5, 4, 2, 0, 3, "abort");
    run(0, 0, PW, PH, 0, 0, "full");

    // asynchronous reset while a byte is waiting in SEND
    @(negedge clk);
    x1 = 3; y1 = 5; width = 4; height = 2; tx_ready = 0; enable = 1;
    cyc = 0;
    while (!tx_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rstmid_reached_send", tx_valid, 1);
    #2 reset = 0;
    #1;
    chk("rstmid_state", int'(dut.state), 0);
    chk("rstmid_outs", int'({row, column, pixel, ram_read_enable, tx_data, tx_valid, done}), 0);
    @(negedge clk);
    reset = 1; enable = 0;
    cyc = 0;
    repeat (5) begin
      @(negedge clk);
      if (ram_read_enable || tx_valid || done) cyc++;
    end
    chk("rstmid_waits", cyc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
